// File: rtl/map_cell_reader.sv
// -----------------------------------------------------------------------------
// map_cell_reader
//
// Read side of the occupancy-grid RAM (128 columns x 32 rows of 8-bit words).
// A world coordinate pair in signed 14.18 fixed point selects the 2x2 cell
// neighbourhood whose lower-left corner is (ix, iy). The four words are fetched
// through a pipelined read port with READ_LATENCY cycles of latency. They are
// returned together with the fractional parts of the coordinates, for use by
// the scan-matching datapath.
//
// Optional feature:
//   MAP_CELL_READER_INTERP_EN  when defined, adds one INTERP cycle that
//                              computes a bilinear blend of the four cells
//                              into rsp_value. When undefined, rsp_value is 0.
//
// Parameters:
//   READ_LATENCY  cycles from mem_rd_en to valid mem_rd_data (legal: 1..4)
//   OOB_VALUE     word reported for every cell of an out-of-map neighbourhood
//
// Ports:
//   clk          in   single clock, all logic on posedge
//   reset        in   synchronous, active-high
//   req_valid    in   coordinate request valid
//   req_ready    out  block can accept a request (IDLE and not in reset)
//   req_x/req_y  in   32b signed fixed point, integer [31:18], fraction [17:0]
//   mem_rd_en    out  read strobe to the grid RAM
//   mem_rd_x     out  7b column address (held after the last read)
//   mem_rd_y     out  5b row address (held after the last read)
//   mem_rd_data  in   8b word, valid READ_LATENCY cycles after mem_rd_en
//   rsp_valid    out  response valid, held until rsp_ready
//   rsp_ready    in   consumer accepts the response
//   rsp_cells    out  {c11, c01, c10, c00}, where cXY = cell (ix+X, iy+Y)
//   rsp_frac_x   out  fraction of req_x latched at accept
//   rsp_frac_y   out  fraction of req_y latched at accept
//   rsp_oob      out  neighbourhood left the map; cells hold OOB_VALUE
//   rsp_value    out  bilinear result (0 when interpolation is compiled out)
// -----------------------------------------------------------------------------
module map_cell_reader #(
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [7:0]  OOB_VALUE    = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_x,
  input  logic [31:0] req_y,
  output logic        mem_rd_en,
  output logic [6:0]  mem_rd_x,
  output logic [4:0]  mem_rd_y,
  input  logic [7:0]  mem_rd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_cells,
  output logic [17:0] rsp_frac_x,
  output logic [17:0] rsp_frac_y,
  output logic        rsp_oob,
  output logic [7:0]  rsp_value
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OOB,
    S_INTERP,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Request decode: integer parts are signed, so negative coordinates are
  // caught by the same range compare as the upper edges.
  logic signed [13:0] w_ix;
  logic signed [13:0] w_iy;
  logic               w_oob;
  logic               w_accept;

  assign w_ix     = req_x[31:18];
  assign w_iy     = req_y[31:18];
  assign w_oob    = (w_ix < 14'sd0) || (w_ix > 14'sd126) ||
                    (w_iy < 14'sd0) || (w_iy > 14'sd30);
  assign req_ready = (r_state == S_IDLE) && !reset;
  assign w_accept = req_valid && req_ready;

  // Latched request and read sequencing
  logic [6:0]  r_base_x;
  logic [4:0]  r_base_y;
  logic [17:0] r_frac_x;
  logic [17:0] r_frac_y;
  logic [1:0]  r_issue_idx;    // index of the read currently on the bus
  logic [1:0]  w_issue_nxt;
  logic        r_mem_rd_en;
  logic [6:0]  r_mem_rd_x;
  logic [4:0]  r_mem_rd_y;

  assign w_issue_nxt = r_issue_idx + 2'd1;

  // Return tagging: one valid bit per cycle of read latency. A set bit at the
  // tail marks mem_rd_data as ours; returns land in slots in issue order.
  logic [READ_LATENCY-1:0] r_vld_sr;
  logic                    w_ret;
  logic [1:0]              r_cap_idx;
  logic [31:0]             r_cells;
  logic                    r_oob;

  assign w_ret = r_vld_sr[READ_LATENCY-1];

`ifdef MAP_CELL_READER_INTERP_EN
  // Bilinear blend: weights are the top 8 fraction bits, so (256 - f) needs
  // 9 bits. Every product is kept at its full width; only the final 24-bit
  // sum is truncated to its top byte.
  logic [7:0]  r_value;
  logic [7:0]  w_fx;
  logic [7:0]  w_fy;
  logic [8:0]  w_fx_inv;
  logic [8:0]  w_fy_inv;
  logic [15:0] w_v0;
  logic [15:0] w_v1;
  logic [23:0] w_v;

  assign w_fx     = r_frac_x[17:10];
  assign w_fy     = r_frac_y[17:10];
  assign w_fx_inv = 9'd256 - {1'b0, w_fx};
  assign w_fy_inv = 9'd256 - {1'b0, w_fy};
  assign w_v0     = 16'(r_cells[7:0])   * 16'(w_fx_inv) + 16'(r_cells[15:8])  * 16'(w_fx);
  assign w_v1     = 16'(r_cells[23:16]) * 16'(w_fx_inv) + 16'(r_cells[31:24]) * 16'(w_fx);
  assign w_v      = 24'(w_v0) * 24'(w_fy_inv) + 24'(w_v1) * 24'(w_fy);
  assign rsp_value = r_value;
`else
  assign rsp_value = 8'd0;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and response valid
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    rsp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_oob ? S_OOB : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_issue_idx == 2'd3) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // The fourth return is being captured on this edge.
        if (w_ret && (r_cap_idx == 2'd3)) begin
`ifdef MAP_CELL_READER_INTERP_EN
          w_state_nxt = S_INTERP;
`else
          w_state_nxt = S_RESP;
`endif
        end
      end
      S_INTERP: begin
        w_state_nxt = S_RESP;
      end
      S_OOB: begin
        // Out-of-map answers are ready immediately; a stalled consumer parks
        // the block in RESP like any other response.
        rsp_valid   = 1'b1;
        w_state_nxt = rsp_ready ? S_IDLE : S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: request latch, read issue, return capture
  // ---------------------------------------------------------------------------
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge value of every other register, independent
  // of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Clearing the tag pipeline discards any returns still in flight.
      r_vld_sr    <= '0;
      r_cap_idx   <= 2'd0;
      r_issue_idx <= 2'd0;
      r_base_x    <= 7'd0;
      r_base_y    <= 5'd0;
      r_frac_x    <= 18'd0;
      r_frac_y    <= 18'd0;
      r_mem_rd_en <= 1'b0;
      r_mem_rd_x  <= 7'd0;
      r_mem_rd_y  <= 5'd0;
      r_cells     <= 32'd0;
      r_oob       <= 1'b0;
`ifdef MAP_CELL_READER_INTERP_EN
      r_value     <= 8'd0;
`endif
    end else begin
      r_vld_sr[0] <= r_mem_rd_en;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        r_vld_sr[i] <= r_vld_sr[i-1];
      end

      if (w_accept) begin
        r_frac_x    <= req_x[17:0];
        r_frac_y    <= req_y[17:0];
        r_base_x    <= w_ix[6:0];
        r_base_y    <= w_iy[4:0];
        r_issue_idx <= 2'd0;
        r_cap_idx   <= 2'd0;
        r_oob       <= w_oob;
        if (w_oob) begin
          r_cells <= {4{OOB_VALUE}};
`ifdef MAP_CELL_READER_INTERP_EN
          r_value <= OOB_VALUE;
`endif
        end else begin
          // First read (c00) goes out in the cycle after accept.
          r_mem_rd_en <= 1'b1;
          r_mem_rd_x  <= w_ix[6:0];
          r_mem_rd_y  <= w_iy[4:0];
        end
      end

      // Read order c00, c10, c01, c11: bit 0 of the index steps x, bit 1 steps y.
      if (r_state == S_ISSUE) begin
        if (r_issue_idx == 2'd3) begin
          r_mem_rd_en <= 1'b0;
        end else begin
          r_issue_idx <= w_issue_nxt;
          r_mem_rd_x  <= r_base_x + {6'd0, w_issue_nxt[0]};
          r_mem_rd_y  <= r_base_y + {4'd0, w_issue_nxt[1]};
        end
      end

      if (w_ret) begin
        r_cells[{r_cap_idx, 3'b000} +: 8] <= mem_rd_data;
        r_cap_idx                         <= r_cap_idx + 2'd1;
      end

`ifdef MAP_CELL_READER_INTERP_EN
      if (r_state == S_INTERP) begin
        r_value <= w_v[23:16];
      end
`endif
    end
  end

  assign mem_rd_en  = r_mem_rd_en;
  assign mem_rd_x   = r_mem_rd_x;
  assign mem_rd_y   = r_mem_rd_y;
  assign rsp_cells  = r_cells;
  assign rsp_frac_x = r_frac_x;
  assign rsp_frac_y = r_frac_y;
  assign rsp_oob    = r_oob;

endmodule

// File: tb/tb_map_cell_reader.sv
// -----------------------------------------------------------------------------
// tb_map_cell_reader
//
// Two instances of map_cell_reader share one clock and one grid RAM model:
//   dut 0: READ_LATENCY=1, OOB_VALUE=8'h00
//   dut 1: READ_LATENCY=3, OOB_VALUE=8'h5A
// The RAM holds RAM[row][col] = (row*16 + col) mod 256, except for one
// neighbourhood rewritten to 0/255 for the interpolation vector.
// A table of requests with hand-computed expectations runs through do_req().
// Hand-written sequences cover reset values and the mid-read reset.
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_map_cell_reader;

`ifdef MAP_CELL_READER_INTERP_EN
  localparam int INTERP = 1;
`else
  localparam int INTERP = 0;
`endif

  logic             clk = 1'b0;
  logic [1:0]       rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_x;
  logic [1:0][31:0] req_y;
  logic [1:0]       mem_rd_en;
  logic [1:0][6:0]  mem_rd_x;
  logic [1:0][4:0]  mem_rd_y;
  logic [1:0][7:0]  mem_rd_data;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [1:0][31:0] rsp_cells;
  logic [1:0][17:0] rsp_frac_x;
  logic [1:0][17:0] rsp_frac_y;
  logic [1:0]       rsp_oob;
  logic [1:0][7:0]  rsp_value;

  logic [7:0] ram [32][128];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [7:0] pipe [L];

    // RAM read port model: data appears L cycles after the strobe; 8'hEE
    // marks cycles that carry no read.
    always @(posedge clk) begin
      pipe[0] <= mem_rd_en[g] ? ram[mem_rd_y[g]][mem_rd_x[g]] : 8'hEE;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rd_data[g] = pipe[L-1];

    map_cell_reader #(
      .READ_LATENCY (L),
      .OOB_VALUE    ((g == 0) ? 8'h00 : 8'h5A)
    ) u_dut (
      .clk         (clk),
      .reset       (rst[g]),
      .req_valid   (req_valid[g]),
      .req_ready   (req_ready[g]),
      .req_x       (req_x[g]),
      .req_y       (req_y[g]),
      .mem_rd_en   (mem_rd_en[g]),
      .mem_rd_x    (mem_rd_x[g]),
      .mem_rd_y    (mem_rd_y[g]),
      .mem_rd_data (mem_rd_data[g]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_ready   (rsp_ready[g]),
      .rsp_cells   (rsp_cells[g]),
      .rsp_frac_x  (rsp_frac_x[g]),
      .rsp_frac_y  (rsp_frac_y[g]),
      .rsp_oob     (rsp_oob[g]),
      .rsp_value   (rsp_value[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;
  int last_rx [2];
  int last_ry [2];

  typedef struct {
    int          d;
    logic [31:0] x;
    logic [31:0] y;
    logic        oob;
    logic [31:0] cells;
    logic [7:0]  value_i;   // expected rsp_value when interpolation is built in
    int          hold;      // cycles rsp_ready stays low after rsp_valid
  } vec_t;

  vec_t vecs [$];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int d, input logic [31:0] x, input logic [31:0] y,
                              input logic oob, input logic [31:0] cells,
                              input logic [7:0] value_i, input int hold);
    vec_t v;
    v.d = d; v.x = x; v.y = y; v.oob = oob; v.cells = cells;
    v.value_i = value_i; v.hold = hold;
    return v;
  endfunction

  // One complete request/response transaction, called at a falling edge.
  task automatic do_req(input vec_t v, input string name);
    int          d;
    int          rsp_n;
    int          n_rd;
    int          rd_n [4];
    logic [6:0]  rd_x [4];
    logic [4:0]  rd_y [4];
    int          ix;
    int          iy;
    int          exp_lat;
    logic [7:0]  exp_value;
    d = v.d;
    ix = int'($signed(v.x[31:18]));
    iy = int'($signed(v.y[31:18]));
    exp_lat   = v.oob ? 1 : 5 + lat_of(d) + INTERP;
    exp_value = (INTERP != 0) ? v.value_i : 8'h00;

    for (int k = 0; k < 50 && !req_ready[d]; k++) @(negedge clk);
    check({name, " req_ready"}, 64'(req_ready[d]), 64'd1);
    req_valid[d] = 1'b1;
    req_x[d]     = v.x;
    req_y[d]     = v.y;
    @(negedge clk);
    req_valid[d] = 1'b0;

    // Cycle k after the accept cycle: log reads, stop at the first rsp_valid.
    rsp_n = -1;
    n_rd  = 0;
    for (int k = 1; k <= 40; k++) begin
      if (mem_rd_en[d]) begin
        if (n_rd < 4) begin
          rd_n[n_rd] = k;
          rd_x[n_rd] = mem_rd_x[d];
          rd_y[n_rd] = mem_rd_y[d];
        end
        n_rd++;
      end
      if (rsp_valid[d]) begin
        rsp_n = k;
        break;
      end
      @(negedge clk);
    end
    check({name, " latency"}, 64'(rsp_n), 64'(exp_lat));

    if (v.oob) begin
      check({name, " reads"}, 64'(n_rd), 64'd0);
    end else begin
      check({name, " reads"}, 64'(n_rd), 64'd4);
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s rd%0d cyc/x/y", name, i),
              {32'(rd_n[i]), 16'(rd_x[i]), 16'(rd_y[i])},
              {32'(i + 1), 16'(ix + (i % 2)), 16'(iy + (i / 2))});
      end
      last_rx[d] = ix + 1;
      last_ry[d] = iy + 1;
    end

    if (rsp_n > 0) begin
      check({name, " cells"}, 64'(rsp_cells[d]), 64'(v.cells));
      check({name, " oob/value"}, 64'({rsp_oob[d], rsp_value[d]}), 64'({v.oob, exp_value}));
      check({name, " frac"}, 64'({rsp_frac_x[d], rsp_frac_y[d]}), 64'({v.x[17:0], v.y[17:0]}));
      check({name, " rd hold"}, 64'({mem_rd_en[d], mem_rd_x[d], mem_rd_y[d]}),
            64'({1'b0, 7'(last_rx[d]), 5'(last_ry[d])}));
    end

    // Consumer stall, with a competing request that must not be taken.
    if (v.hold > 0) begin
      req_valid[d] = 1'b1;
      req_x[d]     = 32'h0008_0000;
      req_y[d]     = 32'h0008_0000;
    end
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check($sformatf("%s stall%0d ctl", name, h),
            64'({rsp_valid[d], req_ready[d], rsp_oob[d], rsp_value[d], rsp_frac_x[d], rsp_frac_y[d]}),
            64'({1'b1, 1'b0, v.oob, exp_value, v.x[17:0], v.y[17:0]}));
      check($sformatf("%s stall%0d cells", name, h), 64'(rsp_cells[d]), 64'(v.cells));
    end
    req_valid[d] = 1'b0;

    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check({name, " post handshake"}, 64'({rsp_valid[d], req_ready[d]}), 64'(2'b01));
  endtask

  initial begin
    int n_bad;

    rst       = 2'b11;
    req_valid = '0;
    rsp_ready = '0;
    req_x     = '0;
    req_y     = '0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 128; c++)
        ram[r][c] = 8'((r * 16 + c) % 256);
    ram[5][10] = 8'h00;
    ram[5][11] = 8'hFF;
    ram[6][10] = 8'h00;
    ram[6][11] = 8'hFF;
    last_rx = '{0, 0};
    last_ry = '{0, 0};

    //        d  x             y             oob   cells          val_i  hold
    vecs.push_back(mk(0, 32'h0014_0000, 32'h000C_0000, 1'b0, 32'h4645_3635, 8'h35, 0));  // 5.0, 3.0
    vecs.push_back(mk(0, 32'hFFFE_0000, 32'h000C_0000, 1'b1, 32'h0000_0000, 8'h00, 0));  // x=-0.5
    vecs.push_back(mk(0, 32'h01FB_0000, 32'h0079_0000, 1'b0, 32'h6F6E_5F5E, 8'h62, 0));  // 126.75, 30.25
    vecs.push_back(mk(0, 32'h01FC_0000, 32'h000C_0000, 1'b1, 32'h0000_0000, 8'h00, 0));  // x=127.0
    vecs.push_back(mk(0, 32'h0014_0000, 32'h007C_0000, 1'b1, 32'h0000_0000, 8'h00, 0));  // y=31.0
    vecs.push_back(mk(0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h1110_0100, 8'h00, 10)); // origin, stall
    vecs.push_back(mk(0, 32'h0102_0000, 32'h0042_0000, 1'b0, 32'h5150_4140, 8'h48, 0));  // 64.5, 16.5
    vecs.push_back(mk(0, 32'h002A_0000, 32'h0014_0000, 1'b0, 32'hFF00_FF00, 8'h7F, 0));  // fx=128 blend
    vecs.push_back(mk(1, 32'h0014_0000, 32'hFFFC_0000, 1'b1, 32'h5A5A_5A5A, 8'h5A, 3));  // y=-1.0, stall
    vecs.push_back(mk(1, 32'h0014_0000, 32'h000C_0000, 1'b0, 32'h4645_3635, 8'h35, 0));  // L=3

    // Reset values
    repeat (3) @(negedge clk);
    check("in reset req_ready", 64'(req_ready), 64'd0);
    rst = 2'b00;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset ctl d%0d", d),
            64'({rsp_valid[d], mem_rd_en[d], rsp_oob[d], rsp_value[d], mem_rd_x[d], mem_rd_y[d], req_ready[d]}),
            64'({1'b0, 1'b0, 1'b0, 8'h00, 7'd0, 5'd0, 1'b1}));
      check($sformatf("reset data d%0d", d),
            {rsp_cells[d], 14'd0, rsp_frac_x[d][17:0]} | 64'(rsp_frac_y[d]), 64'd0);
    end

    foreach (vecs[i]) do_req(vecs[i], $sformatf("v%0d", i));

    // Reset during the read burst on the READ_LATENCY=3 instance.
    req_valid[1] = 1'b1;
    req_x[1]     = 32'h0050_0000;  // 20.0
    req_y[1]     = 32'h001C_0000;  // 7.0
    check("abort req_ready", 64'(req_ready[1]), 64'd1);
    @(negedge clk);                 // cycle T+1
    req_valid[1] = 1'b0;
    check("abort rd_en", 64'(mem_rd_en[1]), 64'd1);
    n_bad = 0;
    for (int k = 1; k <= 2; k++) begin
      if (rsp_valid[1]) n_bad++;
      @(negedge clk);
    end                             // cycle T+3
    if (rsp_valid[1]) n_bad++;
    rst[1] = 1'b1;
    @(negedge clk);                 // cycle T+4
    rst[1] = 1'b0;
    #1;
    if (rsp_valid[1]) n_bad++;
    check("abort no rsp_valid", 64'(n_bad), 64'd0);
    check("abort idle", 64'({mem_rd_en[1], req_ready[1], rsp_cells[1]}), 64'({1'b0, 1'b1, 32'd0}));
    last_rx[1] = 0;
    last_ry[1] = 0;
    // Accepted immediately, while the aborted returns are still arriving.
    do_req(mk(1, 32'h00A0_0000, 32'h0024_0000, 1'b0, 32'hC9C8_B9B8, 8'hB8, 0), "after abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
